// File: rtl/p0011_pkg.sv
// Shared definitions for the p0011 grid loader, grid RAM and solver.
// Holds grid geometry, ASCII constants, the loader state encoding and
// helpers for classifying stream bytes and sizing the digit accumulator.
package p0011_pkg;

  localparam int unsigned GRID_LEN        = 20;
  localparam int unsigned GRID_CELLS      = GRID_LEN * GRID_LEN;
  localparam int unsigned GRID_ADDR_W     = 9;
  localparam int unsigned GRID_MAX_DIGITS = 3;
  localparam int unsigned GRID_DATA_W     = 8;
  localparam int unsigned CSUM_W          = 16;

  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;

  typedef enum logic [1:0] {
    LD_SEP  = 2'd0,
    LD_NUM  = 2'd1,
    LD_DONE = 2'd2,
    LD_ERR  = 2'd3
  } ld_state_e;

  // Accumulator width: enough for max_digits nines, never below 10 bits.
  function automatic int unsigned acc_width(input int unsigned max_digits);
    int unsigned lim;
    int unsigned w;
    lim = 1;
    for (int unsigned i = 0; i < max_digits; i++) lim = lim * 10;
    w = $clog2(lim);
    return (w < 10) ? 10 : w;
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_sep(input logic [7:0] c);
    return (c == CH_SP) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
  endfunction

endpackage

// File: rtl/p0011_grid_loader_dec_accum.sv
// Decimal digit accumulator for the grid loader.
// Ports: clk/rst_n; clr (priority clear); push (fold digit in); first (digit
// starts a new number); digit (0..9); acc (registered value);
// acc_next_c (value after folding digit, combinational); dig_ovf_c (pushing
// this digit would exceed MAX_DIGITS, combinational).
module p0011_dec_accum
  import p0011_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = GRID_MAX_DIGITS,
  parameter int unsigned ACC_W      = acc_width(GRID_MAX_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             first,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] acc_next_c,
  output logic             dig_ovf_c
);

  localparam int unsigned NDIG_W = $clog2(MAX_DIGITS + 1);

  logic [NDIG_W-1:0] ndig;
  logic [ACC_W-1:0]  base;

  // Fold: a first digit starts from zero rather than the stale accumulator.
  always_comb begin
    base       = first ? '0 : acc;
    acc_next_c = base * ACC_W'(10) + ACC_W'(digit);
    dig_ovf_c  = !first && (ndig == NDIG_W'(MAX_DIGITS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      ndig <= '0;
    end else if (clr) begin
      acc  <= '0;
      ndig <= '0;
    end else if (push) begin
      acc  <= acc_next_c;
      ndig <= first ? NDIG_W'(1) : ndig + NDIG_W'(1);
    end
  end

endmodule

// File: rtl/p0011_grid_loader.sv
// p0011 grid loader: parses an ASCII decimal byte stream into LEN*LEN 8-bit
// values and writes them row-major into the grid RAM.
// Ports: clk, rst_n (async active-low); start (restart from address 0);
// s_valid/s_ready/s_data/s_last (byte stream); wr_en/wr_addr/wr_data (RAM
// write port); count (values written); checksum (running sum of values when
// P0011_LOADER_CHECKSUM_EN is defined, else 0); done, error (sticky status).
module p0011_grid_loader
  import p0011_pkg::*;
#(
  parameter int unsigned LEN        = GRID_LEN,
  parameter int unsigned MAX_DIGITS = GRID_MAX_DIGITS,
  parameter int unsigned ADDR_W     = GRID_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] count,
  output logic [15:0]       checksum,
  output logic              done,
  output logic              error
);

  localparam int unsigned CELLS = LEN * LEN;
  localparam int unsigned ACC_W = acc_width(MAX_DIGITS);

  ld_state_e         state_q, state_nxt;
  logic              hs;
  logic              acc_clr, acc_push, acc_first, commit, wr_nxt;
  logic [ACC_W-1:0]  acc, acc_next_c, commit_val;
  logic              dig_ovf_c;
  logic [ADDR_W-1:0] count_nxt;

  p0011_dec_accum #(
    .MAX_DIGITS (MAX_DIGITS),
    .ACC_W      (ACC_W)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (acc_clr),
    .push       (acc_push),
    .first      (acc_first),
    .digit      (4'(s_data - CH_0)),
    .acc        (acc),
    .acc_next_c (acc_next_c),
    .dig_ovf_c  (dig_ovf_c)
  );

  assign hs = s_valid & s_ready;

  // Next state: classify the accepted byte, then resolve any commit.
  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count;
    acc_clr    = 1'b0;
    acc_push   = 1'b0;
    acc_first  = 1'b0;
    commit     = 1'b0;
    commit_val = acc;
    wr_nxt     = 1'b0;
    if (start) begin
      state_nxt = LD_SEP;
      count_nxt = '0;
      acc_clr   = 1'b1;
    end else if (hs) begin
      case (state_q)
        LD_SEP: begin
          if (is_digit(s_data)) begin
            acc_push  = 1'b1;
            acc_first = 1'b1;
            state_nxt = LD_NUM;
            if (s_last) begin
              commit     = 1'b1;
              commit_val = acc_next_c;
            end
          end else if (is_sep(s_data)) begin
            // Stream ended between numbers without filling the grid.
            if (s_last) state_nxt = LD_ERR;
          end else begin
            state_nxt = LD_ERR;
          end
        end
        LD_NUM: begin
          if (is_digit(s_data)) begin
            if (dig_ovf_c) begin
              state_nxt = LD_ERR;
            end else begin
              acc_push = 1'b1;
              if (s_last) begin
                commit     = 1'b1;
                commit_val = acc_next_c;
              end
            end
          end else if (is_sep(s_data)) begin
            commit    = 1'b1;
            state_nxt = LD_SEP;
          end else begin
            state_nxt = LD_ERR;
          end
        end
        default: ;
      endcase
      if (commit) begin
        if (commit_val > ACC_W'(255)) begin
          state_nxt = LD_ERR;
        end else begin
          wr_nxt    = 1'b1;
          count_nxt = count + ADDR_W'(1);
          if (count_nxt == ADDR_W'(CELLS)) state_nxt = LD_DONE;
          else if (s_last)                 state_nxt = LD_ERR;
          else                             state_nxt = LD_SEP;
        end
      end
      // Committed or abandoned numbers leave the accumulator empty.
      if (commit || (state_nxt == LD_ERR)) acc_clr = 1'b1;
    end
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_SEP;
      s_ready <= 1'b1;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      count   <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      s_ready <= (state_nxt == LD_SEP) || (state_nxt == LD_NUM);
      wr_en   <= wr_nxt;
      count   <= count_nxt;
      done    <= (state_nxt == LD_DONE);
      error   <= (state_nxt == LD_ERR);
      if (wr_nxt) begin
        wr_addr <= count;
        wr_data <= commit_val[7:0];
      end
    end
  end

`ifdef P0011_LOADER_CHECKSUM_EN
  // Running modulo-2^16 sum of every value written to the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      checksum <= '0;
    else if (start)  checksum <= '0;
    else if (wr_nxt) checksum <= checksum + 16'(commit_val[7:0]);
  end
`else
  assign checksum = 16'h0;
`endif

endmodule

// File: tb/tb_p0011_grid_loader.sv
module tb_p0011_grid_loader;
  import p0011_pkg::*;

  localparam int unsigned AW = GRID_ADDR_W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] count;
  logic [15:0]   checksum;
  logic          done;
  logic          error;

  int n_checks = 0;
  int n_err    = 0;

  int log_addr[$];
  int log_data[$];
  int log_done[$];

  typedef struct {
    logic [95:0] txt;
    int          len;
    bit          last;
    int          exp_n;
    int          exp_d0;
    int          exp_d1;
    bit          exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  p0011_grid_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .checksum (checksum),
    .done     (done),
    .error    (error)
  );

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      log_addr.push_back(int'(wr_addr));
      log_data.push_back(int'(wr_data));
      log_done.push_back(int'(done));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int grid_val(input int i);
    if (i == 0)   return 8;
    if (i == 399) return 48;
    return (i * 73 + 5) % 256;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_done.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
    bit took;
    bit hs_done;
    int waited;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    hs_done = 1'b0;
    waited  = 0;
    while (!hs_done && waited < 100) begin
      took = s_ready;
      @(posedge clk);
      #1;
      if (took) hs_done = 1'b1;
      waited++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!hs_done) begin
      n_checks++;
      n_err++;
      $display("FAIL handshake: byte %02h not accepted within 100 cycles", b);
    end
  endtask

  // Decimal digits of v, s_last on final digit if last, then sep unless 0.
  task automatic send_val(input int v, input logic [7:0] sep, input bit last, input int gap_max);
    bit tail;
    tail = last && (sep == 8'h00);
    if (v >= 100) send_byte(8'(48 + v / 100), 1'b0, $urandom_range(0, gap_max));
    if (v >= 10)  send_byte(8'(48 + (v / 10) % 10), 1'b0, $urandom_range(0, gap_max));
    send_byte(8'(48 + v % 10), tail, $urandom_range(0, gap_max));
    if (sep != 8'h00) send_byte(sep, last, $urandom_range(0, gap_max));
  endtask

  // Grid text row by row; the final value carries s_last on its last digit.
  task automatic load_grid(input int gap_max, input int n_vals);
    logic [7:0] sep;
    for (int i = 0; i < n_vals; i++) begin
      if (i == GRID_CELLS - 1)        sep = 8'h00;
      else if (i % GRID_LEN == GRID_LEN - 1) sep = CH_LF;
      else                            sep = CH_SP;
      send_val(grid_val(i), sep, i == GRID_CELLS - 1, gap_max);
    end
  endtask

  function automatic int grid_sum();
    int s;
    s = 0;
    for (int i = 0; i < GRID_CELLS; i++) s += grid_val(i);
    return s % 65536;
  endfunction

  task automatic chk_grid(input string tag);
    int bad;
    int exp_cs;
    bad = 0;
    for (int i = 0; i < log_data.size(); i++)
      if (log_addr[i] != i || log_data[i] != grid_val(i)) bad++;
`ifdef P0011_LOADER_CHECKSUM_EN
    exp_cs = grid_sum();
`else
    exp_cs = 0;
`endif
    chk({tag, "_nwrites"}, log_data.size(), GRID_CELLS);
    chk({tag, "_bad_writes"}, bad, 0);
    chk({tag, "_data0"}, q_at(log_data, 0), 8);
    chk({tag, "_data399"}, q_at(log_data, 399), 48);
    chk({tag, "_done_at_last_wr"}, q_at(log_done, 399), 1);
    chk({tag, "_done_before_last"}, q_at(log_done, 398), 0);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_error"}, int'(error), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_count"}, int'(count), GRID_CELLS);
    chk({tag, "_checksum"}, int'(checksum), exp_cs);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 1);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_checksum"}, int'(checksum), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_error"}, int'(error), 0);
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{txt: 96'("  \r\n\t7   12 "), len: 12, last: 1'b0, exp_n: 2, exp_d0: 7,   exp_d1: 12, exp_err: 1'b0, exp_cnt: 2};
    vecs[1] = '{txt: 96'("12a"),              len: 3,  last: 1'b0, exp_n: 0, exp_d0: 0,   exp_d1: 0,  exp_err: 1'b1, exp_cnt: 0};
    vecs[2] = '{txt: 96'("255 256 "),         len: 8,  last: 1'b0, exp_n: 1, exp_d0: 255, exp_d1: 0,  exp_err: 1'b1, exp_cnt: 1};
    vecs[3] = '{txt: 96'("0012"),             len: 4,  last: 1'b0, exp_n: 0, exp_d0: 0,   exp_d1: 0,  exp_err: 1'b1, exp_cnt: 0};
    vecs[4] = '{txt: 96'("999 "),             len: 4,  last: 1'b0, exp_n: 0, exp_d0: 0,   exp_d1: 0,  exp_err: 1'b1, exp_cnt: 0};
    vecs[5] = '{txt: 96'("3 4"),              len: 3,  last: 1'b1, exp_n: 2, exp_d0: 3,   exp_d1: 4,  exp_err: 1'b1, exp_cnt: 2};
    vecs[6] = '{txt: 96'("9\t"),              len: 2,  last: 1'b1, exp_n: 1, exp_d0: 9,   exp_d1: 0,  exp_err: 1'b1, exp_cnt: 1};
    vecs[7] = '{txt: 96'("0 00 "),            len: 5,  last: 1'b0, exp_n: 2, exp_d0: 0,   exp_d1: 0,  exp_err: 1'b0, exp_cnt: 2};
    vecs[8] = '{txt: 96'("x"),                len: 1,  last: 1'b0, exp_n: 0, exp_d0: 0,   exp_d1: 0,  exp_err: 1'b1, exp_cnt: 0};

    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;

    #12;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Full grid with random valid gaps.
    load_grid(2, GRID_CELLS);
    idle(3);
    chk_grid("grid1");

    // Bytes offered after completion are ignored.
    s_valid = 1'b1;
    s_data  = 8'h35;
    s_last  = 1'b1;
    idle(4);
    s_valid = 1'b0;
    s_last  = 1'b0;
    idle(2);
    chk("after_done_count", int'(count), GRID_CELLS);
    chk("after_done_nwrites", log_data.size(), GRID_CELLS);

    // Short directed streams.
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      pulse_start();
      clear_log();
      for (int k = 0; k < v.len; k++)
        send_byte(v.txt[8*(v.len-1-k) +: 8], v.last && (k == v.len - 1), 0);
      idle(3);
      chk($sformatf("vec%0d_nwrites", i), log_data.size(), v.exp_n);
      chk($sformatf("vec%0d_error", i), int'(error), int'(v.exp_err));
      chk($sformatf("vec%0d_count", i), int'(count), v.exp_cnt);
      chk($sformatf("vec%0d_s_ready", i), int'(s_ready), int'(!v.exp_err));
      if (v.exp_n >= 1) begin
        chk($sformatf("vec%0d_addr0", i), q_at(log_addr, 0), 0);
        chk($sformatf("vec%0d_data0", i), q_at(log_data, 0), v.exp_d0);
      end
      if (v.exp_n >= 2) begin
        chk($sformatf("vec%0d_addr1", i), q_at(log_addr, 1), 1);
        chk($sformatf("vec%0d_data1", i), q_at(log_data, 1), v.exp_d1);
      end
    end

    // Error then start recovery.
    pulse_start();
    clear_log();
    send_byte(8'h31, 1'b0, 0);
    send_byte(8'h32, 1'b0, 0);
    send_byte(8'h61, 1'b0, 0);
    idle(2);
    chk("err_error", int'(error), 1);
    chk("err_s_ready", int'(s_ready), 0);
    chk("err_nwrites", log_data.size(), 0);
    pulse_start();
    chk("recover_error", int'(error), 0);
    chk("recover_count", int'(count), 0);
    chk("recover_s_ready", int'(s_ready), 1);

    // Start coincident with a handshake drops the byte.
    s_valid = 1'b1;
    s_data  = 8'h35;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    s_valid = 1'b0;
    send_byte(CH_SP, 1'b0, 0);
    idle(2);
    chk("start_drop_nwrites", log_data.size(), 0);
    chk("start_drop_count", int'(count), 0);
    send_byte(8'h36, 1'b0, 0);
    send_byte(CH_SP, 1'b0, 0);
    idle(2);
    chk("start_drop_data", q_at(log_data, 0), 6);
    chk("start_drop_addr", q_at(log_addr, 0), 0);

    // s_last after ten numbers: short grid.
    pulse_start();
    clear_log();
    for (int k = 1; k <= 10; k++)
      send_val(k, (k == 10) ? 8'h00 : CH_SP, k == 10, 0);
    idle(3);
    chk("short_count", int'(count), 10);
    chk("short_error", int'(error), 1);
    chk("short_nwrites", log_data.size(), 10);
    chk("short_data9", q_at(log_data, 9), 10);
    chk("short_s_ready", int'(s_ready), 0);

    // Asynchronous reset mid-load, then a full reload.
    pulse_start();
    clear_log();
    load_grid(1, 50);
    idle(2);
    chk("midload_count", int'(count), 50);
    chk("midload_nwrites", log_data.size(), 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    idle(1);
    load_grid(2, GRID_CELLS);
    idle(3);
    chk_grid("grid2");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
